// File: rtl/Full_adder.sv
// Single-bit full adder: sum s and carry c of a + b + d.
module Full_adder (
    input  logic a,
    input  logic b,
    input  logic d,
    output logic c,
    output logic s
);

    assign s = a ^ b ^ d;
    assign c = (a & b) | (d & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one Full_adder reused across WIDTH bits, LSB first, with a
// start/busy/done handshake and registered sum, carry-out and signed overflow.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MsbCnt  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] psum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             c_msb_q;
    logic             fa_c;
    logic             fa_s;
    logic [WIDTH-1:0] psum_next;

    Full_adder u_fa (
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .d (carry_q),
        .c (fa_c),
        .s (fa_s)
    );

    assign psum_next = {fa_s, psum_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    // The done cycle also accepts start, giving back-to-back operation.
                    if (start) begin
                        a_sh_q  <= a_in;
                        b_sh_q  <= b_in;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        psum_q  <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    psum_q  <= psum_next;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    // Carry leaving bit WIDTH-2 is the carry into the MSB.
                    if (cnt_q == MsbCnt) begin
                        c_msb_q <= fa_c;
                    end
                    if (cnt_q == LastCnt) begin
                        sum     <= psum_next;
                        cout    <= fa_c;
                        ovf     <= c_msb_q ^ fa_c;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks of serial_adder_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, ovf;
    logic [7:0]  sum;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a_in  (a16),
        .b_in  (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16),
        .ovf   (ovf16)
    );

    // Starts one 8-bit op; lat counts post-edge samples from the accepting edge
    // (sample 1) up to the one showing done. busy_cnt counts samples with busy=1.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                            output int lat);
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, ovf);
        end
        checks++;
        if ({busy16, done16, sum16, cout16, ovf16} !== 20'h0) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b sum=%h, required all 0",
                     busy16, done16, sum16);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(8'h5A, 8'h3C, 1'b0, lat, bc);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required 9", lat);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, required 8", bc);
        end
        checks++;
        if ({cout, sum, ovf} !== {1'b0, 8'h96, 1'b1}) begin
            errors++;
            $display("FAIL basic_result: got cout=%b sum=%h ovf=%b, required 0 96 1",
                     cout, sum, ovf);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h80};
        logic [7:0] vb [3] = '{8'h01, 8'h00, 8'h80};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [9:0] exp [3] = '{{1'b1, 8'h00, 1'b0}, {1'b0, 8'h80, 1'b1},
                                {1'b1, 8'h00, 1'b1}};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], lat, bc);
            checks++;
            if ({cout, sum, ovf} !== exp[i] || lat !== 9) begin
                errors++;
                $display("FAIL vector%0d: got cout=%b sum=%h ovf=%b lat=%0d, required %b %h %b 9",
                         i, cout, sum, ovf, lat, exp[i][9], exp[i][8:1], exp[i][0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = 8'h00; b_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        // Third RUN sample: pulse start with new operands for one edge.
        a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d, required 1", ndone);
        end
        checks++;
        if ({cout, sum} !== {1'b0, 8'h30}) begin
            errors++;
            $display("FAIL ignore_result: got cout=%b sum=%h, required 0 30", cout, sum);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(8'h03, 8'h04, 1'b0, lat, bc);
        checks++;
        if (sum !== 8'h07 || lat !== 9) begin
            errors++;
            $display("FAIL b2b_first: got sum=%h lat=%0d, required 07 9", sum, lat);
        end
        a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_gap: busy=%b after done-cycle start, required 1", busy);
        end
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 9 || sum !== 8'h02 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d sum=%h cout=%b, required 9 02 0",
                     lat, sum, cout);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone = 0;
        int lat, bc;
        @(negedge clk);
        a_in = 8'hAA; b_in = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d done pulses, required 0", ndone);
        end
        run_op(8'hAA, 8'h55, 1'b0, lat, bc);
        checks++;
        if ({cout, sum, ovf} !== {1'b0, 8'hFF, 1'b0} || lat !== 9) begin
            errors++;
            $display("FAIL midrun_restart: got cout=%b sum=%h ovf=%b lat=%0d, required 0 ff 0 9",
                     cout, sum, ovf, lat);
        end
    endtask

    task automatic test_random8();
        int lat, bc, bad = 0;
        logic [7:0] a, b;
        logic       c;
        logic [8:0] ref_sum;
        logic       ref_ovf;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            ref_sum = {1'b0, a} + {1'b0, b} + {8'b0, c};
            ref_ovf = (a[7] == b[7]) && (ref_sum[7] != a[7]);
            run_op(a, b, c, lat, bc);
            checks++;
            if ({cout, sum} !== ref_sum || ovf !== ref_ovf || lat !== 9) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL rand8 %h+%h+%b: got %b_%h ovf=%b lat=%0d, required %h ovf=%b lat=9",
                             a, b, c, cout, sum, ovf, lat, ref_sum, ref_ovf);
            end
        end
    endtask

    task automatic test_random16();
        int lat, bad = 0;
        logic [15:0] a, b;
        logic        c;
        logic [16:0] ref_sum;
        logic        ref_ovf;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            ref_sum = {1'b0, a} + {1'b0, b} + {16'b0, c};
            ref_ovf = (a[15] == b[15]) && (ref_sum[15] != a[15]);
            run_op16(a, b, c, lat);
            checks++;
            if ({cout16, sum16} !== ref_sum || ovf16 !== ref_ovf || lat !== 17) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL rand16 %h+%h+%b: got %b_%h ovf=%b lat=%0d, required %h ovf=%b lat=17",
                             a, b, c, cout16, sum16, ovf16, lat, ref_sum, ref_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random8();
        test_random16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
